// File: rtl/cec_frame_sequencer.sv
// cec_frame_sequencer
// Buffers one CEC message (header, opcode, operands) and feeds it byte by
// byte to a downstream CEC transmitter. It waits for bus signal-free time
// before the first byte and again before each retransmission. It guards
// every byte result with a 64 ms watchdog.
//
// Build option: define CEC_SEQ_RETRY_EN to retransmit the whole message up
// to MSG_RETRIES times after a rejected byte. Without it, the first
// rejection fails the message.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   msg_wr_en/msg_wr_data : append a byte to the buffer (IDLE only)
//   msg_send              : start transmission of the buffered message
//   msg_busy              : message in flight
//   msg_done/msg_failed   : one-cycle completion pulses
//   msg_count             : bytes currently buffered
//   cec_in                : sampled bus level for free-time detection
//   tx_data_*             : byte handshake with the CEC transmitter
module cec_frame_sequencer #(
    parameter int CLK_KHZ     = 27000,
    parameter int MAX_BYTES   = 16,
    parameter int MSG_RETRIES = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           msg_wr_en,
    input  logic [7:0]                     msg_wr_data,
    input  logic                           msg_send,
    output logic                           msg_busy,
    output logic                           msg_done,
    output logic                           msg_failed,
    output logic [$clog2(MAX_BYTES+1)-1:0] msg_count,
    input  logic                           cec_in,
    output logic                           tx_data_ready,
    output logic [7:0]                     tx_data_out,
    output logic                           tx_data_eom,
    output logic                           tx_data_broadcast,
    input  logic                           tx_data_acknowledged,
    input  logic                           tx_data_rejected
);
    localparam int CW    = $clog2(MAX_BYTES+1);
    localparam int IW    = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int RW    = (MSG_RETRIES > 0) ? $clog2(MSG_RETRIES+1) : 1;
    // 2.4 ms bit period: 5 bits = 12 ms, 3 bits = 7.2 ms
    localparam int FREE5 = 12 * CLK_KHZ;
    localparam int FREE3 = (36 * CLK_KHZ) / 5;
    localparam int WDOG  = 64 * CLK_KHZ;
    localparam int FW    = $clog2(FREE5+1);
    localparam int WW    = $clog2(WDOG+1);

    localparam logic [FW-1:0] F5_LAST = FW'(FREE5 - 1);
    localparam logic [FW-1:0] F3_LAST = FW'(FREE3 - 1);
    localparam logic [FW-1:0] F_SAT   = FW'(FREE5);
    localparam logic [WW-1:0] W_LAST  = WW'(WDOG - 1);
    localparam logic [WW-1:0] W_SAT   = WW'(WDOG);

    typedef enum logic [2:0] {IDLE, WAIT_FREE, PRESENT, WAIT_RESULT, FINISH} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [MAX_BYTES];
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [RW-1:0] att_q, att_d;
    logic [FW-1:0] free_q, free_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          retry_q, retry_d;
    logic          done_q, done_d, fail_q, fail_d;
    logic          bcast_q, bcast_d, eom_q, eom_d;
    logic [7:0]    txd_q, txd_d;
    logic          wr_ok, can_retry;
    logic [FW-1:0] free_last;

    assign free_last = retry_q ? F3_LAST : F5_LAST;

`ifdef CEC_SEQ_RETRY_EN
    assign can_retry = (att_q != '0);
`else
    // The retry budget is still tracked but never consulted.
    assign can_retry = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        att_d   = att_q;
        free_d  = '0;
        wd_d    = '0;
        retry_d = retry_q;
        done_d  = 1'b0;
        fail_d  = 1'b0;
        bcast_d = bcast_q;
        txd_d   = txd_q;
        eom_d   = eom_q;
        wr_ok   = 1'b0;
        case (state_q)
            IDLE: begin
                if (msg_send && cnt_q != '0) begin
                    state_d = WAIT_FREE;
                    idx_d   = '0;
                    att_d   = RW'(MSG_RETRIES);
                    retry_d = 1'b0;
                    bcast_d = (mem_q[0][3:0] == 4'hF);
                end else if (msg_wr_en && cnt_q < CW'(MAX_BYTES)) begin
                    wr_ok = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_FREE: begin
                // The counter clears whenever the bus is seen low.
                if (cec_in) begin
                    if (free_q >= free_last) state_d = PRESENT;
                    else free_d = (free_q == F_SAT) ? free_q : free_q + FW'(1);
                end
            end
            PRESENT: state_d = WAIT_RESULT;
            WAIT_RESULT: begin
                // A rejection takes priority over a simultaneous ack.
                if (tx_data_rejected) begin
                    if (can_retry) begin
                        att_d   = att_q - RW'(1);
                        idx_d   = '0;
                        retry_d = 1'b1;
                        state_d = WAIT_FREE;
                    end else begin
                        fail_d  = 1'b1;
                        state_d = FINISH;
                    end
                end else if (tx_data_acknowledged) begin
                    if (eom_q) begin
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = PRESENT;
                    end
                end else if (wd_q >= W_LAST) begin
                    fail_d  = 1'b1;
                    state_d = FINISH;
                end else begin
                    wd_d = (wd_q == W_SAT) ? wd_q : wd_q + WW'(1);
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Byte and eom are latched on entry to PRESENT and then held.
        if (state_d == PRESENT) begin
            txd_d = mem_q[idx_d];
            eom_d = (CW'(idx_d) == cnt_q - CW'(1));
        end
        if (state_d == FINISH) begin
            cnt_d   = '0;
            bcast_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            att_q   <= '0;
            free_q  <= '0;
            wd_q    <= '0;
            retry_q <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            bcast_q <= 1'b0;
            txd_q   <= '0;
            eom_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            att_q   <= att_d;
            free_q  <= free_d;
            wd_q    <= wd_d;
            retry_q <= retry_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            bcast_q <= bcast_d;
            txd_q   <= txd_d;
            eom_q   <= eom_d;
        end
    end

    // Buffer storage needs no reset; msg_count defines what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[cnt_q[IW-1:0]] <= msg_wr_data;
    end

    assign msg_busy          = (state_q == WAIT_FREE) || (state_q == PRESENT) ||
                               (state_q == WAIT_RESULT);
    assign tx_data_ready     = (state_q == PRESENT);
    assign msg_done          = done_q;
    assign msg_failed        = fail_q;
    assign msg_count         = cnt_q;
    assign tx_data_out       = txd_q;
    assign tx_data_eom       = eom_q;
    assign tx_data_broadcast = bcast_q;
endmodule
